// File: rtl/usr_serial_sequencer.sv
// Serializer front-end for the 4-bit universal shift register.
// Loads each word, shifts it out LSB- or MSB-first, streams Out back.
module usr_serial_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [3:0]       Din,
  input  logic             Din_dir,
  input  logic             Din_valid,
  output logic             Din_ready,
  input  logic             Fill,
  input  logic [3:0]       Sr_out,
  output logic [1:0]       Sel,
  output logic [3:0]       P_in,
  output logic             R_Shift,
  output logic             L_Shift,
  output logic             Ser_out,
  output logic             Ser_valid,
  input  logic             Ser_ready,
  output logic             Ser_last,
  output logic             Busy,
  output logic [CNT_W-1:0] Words_sent
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_RSH  = 2'b01;
  localparam logic [1:0] SEL_LSH  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  logic [0:0]       state;
  logic [1:0]       idx;
  logic             dir;
  logic [CNT_W-1:0] cnt;

  logic             last_bit;
  logic [1:0]       shift_code;
  logic             sr_unused;

  assign P_in       = Din;
  assign R_Shift    = Fill;
  assign L_Shift    = Fill;
  assign Words_sent = cnt;
  assign Busy       = Ser_valid;

  assign last_bit   = (idx == 2'd3);
  assign shift_code = dir ? SEL_LSH : SEL_RSH;

  // Middle register bits never reach the serial port.
  assign sr_unused  = ^Sr_out[2:1];
  assign Ser_out    = dir ? Sr_out[3] : Sr_out[0];

  always_comb begin
    Sel       = SEL_HOLD;
    Din_ready = 1'b0;
    Ser_valid = 1'b0;
    Ser_last  = 1'b0;
    if (!Rst) begin
      Sel = SEL_HOLD;
    end else if (state == S_IDLE) begin
      Din_ready = 1'b1;
      Sel       = Din_valid ? SEL_LOAD : SEL_HOLD;
    end else begin
      Ser_valid = 1'b1;
      Ser_last  = last_bit;
      Din_ready = Ser_ready && last_bit;
      if (Ser_ready) begin
        // A pending word reloads over the final shift: no bubble.
        if (last_bit && Din_valid)
          Sel = SEL_LOAD;
        else
          Sel = shift_code;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= S_IDLE;
      idx   <= 2'd0;
      dir   <= 1'b0;
      cnt   <= '0;
    end else if (state == S_IDLE) begin
      if (Din_valid) begin
        dir   <= Din_dir;
        idx   <= 2'd0;
        state <= S_SHIFT;
      end
    end else if (Ser_ready) begin
      if (!last_bit) begin
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
        if (Din_valid) begin
          dir <= Din_dir;
          idx <= 2'd0;
        end else begin
          state <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_usr_serial_sequencer.sv
// Scoreboard bench for usr_serial_sequencer with a behavioural
// shift-register environment and a queue-based reference model.
module tb_usr_serial_sequencer;

  localparam int CW = 2;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic [3:0]    Din = 4'd0;
  logic          Din_dir = 1'b0;
  logic          Din_valid = 1'b0;
  logic          Din_ready;
  logic          Fill = 1'b0;
  logic [3:0]    Sr_out;
  logic [1:0]    Sel;
  logic [3:0]    P_in;
  logic          R_Shift;
  logic          L_Shift;
  logic          Ser_out;
  logic          Ser_valid;
  logic          Ser_ready = 1'b0;
  logic          Ser_last;
  logic          Busy;
  logic [CW-1:0] Words_sent;

  usr_serial_sequencer #(.CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst),
    .Din(Din), .Din_dir(Din_dir),
    .Din_valid(Din_valid), .Din_ready(Din_ready),
    .Fill(Fill), .Sr_out(Sr_out),
    .Sel(Sel), .P_in(P_in),
    .R_Shift(R_Shift), .L_Shift(L_Shift),
    .Ser_out(Ser_out), .Ser_valid(Ser_valid),
    .Ser_ready(Ser_ready), .Ser_last(Ser_last),
    .Busy(Busy), .Words_sent(Words_sent)
  );

  always #5 Clk = ~Clk;

  // Universal shift register the sequencer drives.
  logic [3:0] sr;
  always @(posedge Clk) begin
    if (!Rst) sr <= 4'd0;
    else case (Sel)
      2'b01:   sr <= {R_Shift, sr[3:1]};
      2'b10:   sr <= {sr[2:0], L_Shift};
      2'b11:   sr <= P_in;
      default: sr <= sr;
    endcase
  end
  assign Sr_out = sr;

  typedef struct {
    logic bitv;
    logic last;
    logic dir;
  } exp_t;

  typedef struct {
    logic [3:0] d;
    logic       dir;
  } word_t;

  exp_t  sq[$];
  word_t wq[$];
  bit    rq[$];

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  bit mon_on = 0;
  bit acc = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  // Monitor: evaluate the cycle's handshakes ahead of the next edge.
  always @(negedge Clk) begin
    if (mon_on) begin
      logic       e_rdy, e_vld, take, acc_e;
      logic [1:0] e_sel;
      exp_t       e;
      e_vld = Rst && (sq.size() > 0);
      e_rdy = Rst && (sq.size() == 0 ||
                      (Ser_ready && sq.size() == 1));
      take  = e_vld && Ser_ready;
      acc_e = e_rdy && Din_valid;
      if (!Rst)       e_sel = 2'b00;
      else if (acc_e) e_sel = 2'b11;
      else if (take)  e_sel = sq[0].dir ? 2'b10 : 2'b01;
      else            e_sel = 2'b00;
      chk("sel", 32'(Sel), 32'(e_sel));
      chk("din_ready", 32'(Din_ready), 32'(e_rdy));
      chk("ser_valid", 32'(Ser_valid), 32'(e_vld));
      chk("busy", 32'(Busy), 32'(e_vld));
      chk("ser_last", 32'(Ser_last),
          32'(e_vld ? sq[0].last : 1'b0));
      if (e_vld)
        chk("ser_out", 32'(Ser_out), 32'(sq[0].bitv));
      chk("words_sent", 32'(Words_sent),
          32'(exp_cnt % (1 << CW)));
      chk("p_in", 32'(P_in), 32'(Din));
      chk("r_shift", 32'(R_Shift), 32'(Fill));
      chk("l_shift", 32'(L_Shift), 32'(Fill));
      if (!Rst) begin
        sq.delete();
        exp_cnt = 0;
      end else begin
        if (take) begin
          e = sq.pop_front();
          if (e.last) exp_cnt++;
        end
        if (acc_e) begin
          for (int i = 0; i < 4; i++) begin
            e.bitv = Din_dir ? Din[3-i] : Din[i];
            e.last = (i == 3);
            e.dir  = Din_dir;
            sq.push_back(e);
          end
        end
      end
    end
    acc = Din_valid && Din_ready;
  end

  task automatic step(bit rnd);
    @(posedge Clk);
    #1;
    if (acc && wq.size() > 0) void'(wq.pop_front());
    if (wq.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
      Din_valid = 1'b1;
      Din       = wq[0].d;
      Din_dir   = wq[0].dir;
    end else begin
      Din_valid = 1'b0;
      Din       = 4'($urandom);
      Din_dir   = 1'($urandom);
    end
    Fill = 1'($urandom);
    if (Ser_valid && rq.size() > 0)
      Ser_ready = rq.pop_front();
    else
      Ser_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  task automatic steps(int n, bit rnd);
    for (int i = 0; i < n; i++) step(rnd);
  endtask

  task automatic add_word(logic [3:0] d, logic dir);
    word_t w;
    w.d   = d;
    w.dir = dir;
    wq.push_back(w);
  endtask

  task automatic reset_pulse(int n);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
    Rst = 1'b1;
  endtask

  initial begin
    Rst = 1'b0;
    Din_valid = 1'b1;
    Din = 4'hF;
    @(posedge Clk);
    #1;
    mon_on = 1;
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
    Rst = 1'b1;
    Din_valid = 1'b0;

    add_word(4'b1011, 1'b0);
    steps(8, 0);
    add_word(4'b1011, 1'b1);
    steps(8, 0);
    add_word(4'hA, 1'b0);
    add_word(4'h5, 1'b1);
    steps(12, 0);

    rq = '{1, 0, 0, 1, 1, 0, 1};
    add_word(4'hC, 1'b0);
    steps(12, 0);

    // Abandon a word after two bits have been taken.
    add_word(4'($urandom), 1'b0);
    steps(3, 0);
    reset_pulse(1);
    steps(4, 0);

    for (int i = 0; i < 5; i++) add_word(4'($urandom), 1'b0);
    steps(26, 0);

    for (int seg = 0; seg < 3; seg++) begin
      int guard;
      for (int i = 0; i < 100; i++)
        add_word(4'($urandom), 1'($urandom));
      guard = 0;
      while (wq.size() > 0 && guard < 3000) begin
        step(1);
        guard++;
        if (seg < 2 && guard == 150) reset_pulse(2);
      end
      chk("drain", 32'(wq.size()), 32'd0);
      wq.delete();
      steps(10, 0);
    end

    @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
